// File: rtl/bus_transfer_sequencer_pkg.sv
// bus_transfer_sequencer_pkg: FSM state encodings and the register-index to one-hot decode shared by the sequencer
package bus_transfer_sequencer_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
  function automatic logic [7:0] onehot(input logic [2:0] idx);
    return 8'b1 << idx;
  endfunction
endpackage

// File: rtl/bus_transfer_sequencer_if.sv
// bus_transfer_sequencer_if: requester/bus bundle; master drives req/src/dst, slave drives ack/err/oe/ld/busy/grant_id
interface bus_transfer_sequencer_if #(
  parameter int NREG = 4,
  parameter int NREQ = 2,
  localparam int IDXW = $clog2(NREG)
);
  logic [NREQ-1:0]      req;
  logic [NREQ*IDXW-1:0] src;
  logic [NREQ*IDXW-1:0] dst;
  logic [NREQ-1:0]      ack;
  logic                 err;
  logic [NREG-1:0]      oe;
  logic [NREG-1:0]      ld;
  logic                 busy;
  logic [1:0]           grant_id;
  modport master (output req, src, dst, input ack, err, oe, ld, busy, grant_id);
  modport slave (input req, src, dst, output ack, err, oe, ld, busy, grant_id);
endinterface

// File: rtl/bus_transfer_sequencer_rr_arbiter.sv
// bus_transfer_sequencer_rr_arbiter: combinational round-robin pick; ports req_i, ptr_i in; valid_o, idx_o out
module bus_transfer_sequencer_rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [1:0]      ptr_i,
  output logic            valid_o,
  output logic [1:0]      idx_o
);
  int k;
  always_comb begin
    valid_o = 1'b0;
    idx_o = 2'd0;
    k = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      k = (int'(ptr_i) + i) % NREQ;
      if (req_i[k]) begin
        valid_o = 1'b1;
        idx_o = 2'(k);
      end
    end
  end
endmodule

// File: rtl/bus_transfer_sequencer.sv
// bus_transfer_sequencer: round-robin reg-to-reg bus move sequencer; ports clk, reset, bus (req/src/dst in; ack/err/oe/ld/busy/grant_id out)
module bus_transfer_sequencer
  import bus_transfer_sequencer_pkg::*;
#(
  parameter int NREG = 4,
  parameter int NREQ = 2,
  localparam int IDXW = $clog2(NREG)
) (
  input logic clk,
  input logic reset,
  bus_transfer_sequencer_if.slave bus
);
  state_t state_q, state_d;
  logic [IDXW-1:0] src_q, src_d, dst_q, dst_d, src_sel, dst_sel;
  logic [1:0] grant_q, grant_d, rr_q, rr_d, gnt_idx;
  logic gnt_v, bad, pend_q, pend_d;
  logic [NREG-1:0] oe_q, oe_d, ld_q, ld_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic err_q, err_d;
  logic [7:0] src_oh, dst_oh;
  bus_transfer_sequencer_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i(bus.req),
    .ptr_i(rr_q),
    .valid_o(gnt_v),
    .idx_o(gnt_idx)
  );
  assign src_sel = bus.src[int'(gnt_idx)*IDXW +: IDXW];
  assign dst_sel = bus.dst[int'(gnt_idx)*IDXW +: IDXW];
  assign bad = (32'(src_sel) >= NREG) || (32'(dst_sel) >= NREG) || (src_sel == dst_sel);
  always_comb begin
    state_d = state_q;
    src_d = src_q;
    dst_d = dst_q;
    grant_d = grant_q;
    rr_d = rr_q;
    pend_d = pend_q;
    case (state_q)
      ST_IDLE: if (gnt_v) begin
        src_d = src_sel;
        dst_d = dst_sel;
        grant_d = gnt_idx;
        pend_d = bad;
        state_d = bad ? ST_DONE : ST_DRIVE;
      end
      ST_DRIVE: state_d = ST_LOAD;
      ST_LOAD: state_d = ST_DONE;
      default: begin
        state_d = ST_IDLE;
        rr_d = (grant_q == 2'(NREQ - 1)) ? 2'd0 : grant_q + 2'd1;
      end
    endcase
  end
  // Strobes are decoded from next state so they come straight out of flops aligned with the state.
  assign src_oh = onehot(3'(src_d));
  assign dst_oh = onehot(3'(dst_d));
  assign oe_d = (state_d == ST_DRIVE || state_d == ST_LOAD) ? src_oh[NREG-1:0] : '0;
  assign ld_d = (state_d == ST_LOAD) ? dst_oh[NREG-1:0] : '0;
  assign ack_d = (state_d == ST_DONE) ? NREQ'(1) << grant_d : '0;
  assign err_d = (state_d == ST_DONE) && pend_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      src_q <= '0;
      dst_q <= '0;
      grant_q <= 2'd0;
      rr_q <= 2'd0;
      pend_q <= 1'b0;
      oe_q <= '0;
      ld_q <= '0;
      ack_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q <= src_d;
      dst_q <= dst_d;
      grant_q <= grant_d;
      rr_q <= rr_d;
      pend_q <= pend_d;
      oe_q <= oe_d;
      ld_q <= ld_d;
      ack_q <= ack_d;
      err_q <= err_d;
    end
  end
  assign bus.oe = oe_q;
  assign bus.ld = ld_q;
  assign bus.ack = ack_q;
  assign bus.err = err_q;
  assign bus.busy = state_q != ST_IDLE;
  assign bus.grant_id = grant_q;
endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// tb_bus_transfer_sequencer: directed bench for bus_transfer_sequencer with a 4-register bus data model
module tb_bus_transfer_sequencer;
  logic clk = 1'b0;
  logic reset;
  logic pre;
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] r [4];
  logic [7:0] bus_d;
  logic [1:0] exp_ack;
  always #5 clk = ~clk;
  bus_transfer_sequencer_if #(.NREG(4), .NREQ(2)) bi ();
  bus_transfer_sequencer_if #(.NREG(3), .NREQ(2)) b3 ();
  bus_transfer_sequencer #(.NREG(4), .NREQ(2)) dut (.clk(clk), .reset(reset), .bus(bi));
  bus_transfer_sequencer #(.NREG(3), .NREQ(2)) dut3 (.clk(clk), .reset(reset), .bus(b3));
  always_comb begin
    bus_d = 8'h00;
    for (int i = 0; i < 4; i++) if (bi.oe[i]) bus_d = r[i];
  end
  always @(posedge clk) begin
    if (pre) begin
      r[0] <= 8'h11;
      r[1] <= 8'hA5;
      r[2] <= 8'h22;
      r[3] <= 8'h33;
    end else
      for (int i = 0; i < 4; i++) if (bi.ld[i]) r[i] <= bus_d;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    reset = 1'b1;
    pre = 1'b0;
    bi.req = '0;
    bi.src = '0;
    bi.dst = '0;
    b3.req = '0;
    b3.src = '0;
    b3.dst = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", bi.busy, 0);
    chk("rst_oe", bi.oe, 0);
    chk("rst_ld", bi.ld, 0);
    chk("rst_ack", bi.ack, 0);
    chk("rst_grant", bi.grant_id, 0);
    bi.req = 2'b01;
    bi.src = {2'd0, 2'd1};
    bi.dst = {2'd0, 2'd3};
    tick();
    chk("mv_drive_oe", bi.oe, 4'b0010);
    chk("mv_drive_ld", bi.ld, 4'b0000);
    chk("mv_drive_busy", bi.busy, 1);
    tick();
    chk("mv_load_oe", bi.oe, 4'b0010);
    chk("mv_load_ld", bi.ld, 4'b1000);
    chk("mv_load_ack", bi.ack, 0);
    tick();
    chk("mv_done_ack", bi.ack, 2'b01);
    chk("mv_done_err", bi.err, 0);
    chk("mv_done_oe", bi.oe, 0);
    chk("mv_done_ld", bi.ld, 0);
    bi.req = 2'b00;
    tick();
    chk("mv_idle_busy", bi.busy, 0);
    chk("mv_idle_ack", bi.ack, 0);
    bi.req = 2'b01;
    bi.src = {2'd0, 2'd1};
    bi.dst = {2'd0, 2'd3};
    tick();
    tick();
    chk("rl_load_ld", bi.ld, 4'b1000);
    reset = 1'b1;
    bi.req = 2'b00;
    tick();
    chk("rl_oe", bi.oe, 0);
    chk("rl_ld", bi.ld, 0);
    chk("rl_busy", bi.busy, 0);
    chk("rl_ack", bi.ack, 0);
    tick();
    chk("rl_ack2", bi.ack, 0);
    reset = 1'b0;
    tick();
    chk("rl_post_busy", bi.busy, 0);
    chk("rl_post_grant", bi.grant_id, 0);
    chk("rl_post_ack", bi.ack, 0);
    bi.req = 2'b11;
    bi.src = {2'd2, 2'd0};
    bi.dst = {2'd3, 2'd1};
    for (int i = 1; i <= 16; i++) begin
      tick();
      exp_ack = (i % 4 == 3) ? (((i / 4) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      chk("rr_ack", bi.ack, exp_ack);
      chk("rr_oe_onehot0", $onehot0(bi.oe), 1);
      if (i == 15) bi.req = 2'b00;
    end
    chk("rr_end_busy", bi.busy, 0);
    bi.req = 2'b01;
    bi.src = {2'd0, 2'd2};
    bi.dst = {2'd0, 2'd2};
    b3.req = 2'b01;
    b3.src = {2'd0, 2'd1};
    b3.dst = {2'd0, 2'd3};
    tick();
    chk("inv_ack", bi.ack, 2'b01);
    chk("inv_err", bi.err, 1);
    chk("inv_oe", bi.oe, 0);
    chk("inv_ld", bi.ld, 0);
    chk("inv3_ack", b3.ack, 2'b01);
    chk("inv3_err", b3.err, 1);
    chk("inv3_oe", b3.oe, 0);
    chk("inv3_ld", b3.ld, 0);
    bi.req = 2'b00;
    b3.req = 2'b00;
    tick();
    chk("inv_after_ack", bi.ack, 0);
    chk("inv_after_err", bi.err, 0);
    chk("inv3_after_err", b3.err, 0);
    bi.req = 2'b01;
    bi.src = {2'd0, 2'd3};
    bi.dst = {2'd0, 2'd0};
    tick();
    chk("hold_drive_oe", bi.oe, 4'b1000);
    bi.req = 2'b00;
    bi.src = {2'd0, 2'd1};
    bi.dst = {2'd0, 2'd2};
    tick();
    chk("hold_load_oe", bi.oe, 4'b1000);
    chk("hold_load_ld", bi.ld, 4'b0001);
    tick();
    chk("hold_ack", bi.ack, 2'b01);
    chk("hold_err", bi.err, 0);
    tick();
    chk("hold_idle_busy", bi.busy, 0);
    pre = 1'b1;
    tick();
    pre = 1'b0;
    chk("data_pre_r1", r[1], 8'hA5);
    bi.req = 2'b01;
    bi.src = {2'd0, 2'd1};
    bi.dst = {2'd0, 2'd2};
    tick();
    tick();
    tick();
    chk("data_ack", bi.ack, 2'b01);
    bi.req = 2'b00;
    chk("data_r2", r[2], 8'hA5);
    chk("data_r0", r[0], 8'h11);
    chk("data_r1", r[1], 8'hA5);
    chk("data_r3", r[3], 8'h33);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
